// File: rtl/display_scan_mux.sv
// Time-multiplexed N-digit hex scanner for a common-anode 7-segment display, with tear-free frame-boundary commit.
// Optional leading-zero blanking is enabled by defining DISP_LZB_EN.
module display_scan_mux #(
  parameter int N_DIG       = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*N_DIG-1:0] data_in,
  input  logic               load,
  output logic               ready,
  output logic [3:0]         s_muxfue,
  output logic [N_DIG-1:0]   an,
  output logic               frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [N_DIG-1:0][3:0]   r_disp;
  logic [N_DIG-1:0][3:0]   r_pend;
  logic                    r_pend_v;

  logic w_tick;
  logic w_frame_end;
  logic [N_DIG-1:0] w_an_scan;

  assign w_tick      = (r_cnt == CNT_LAST);
  assign w_frame_end = w_tick && (r_idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_disp   <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick)
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      // Commit wins over capture: a load is only taken when the buffer is empty.
      if (w_frame_end && r_pend_v) begin
        r_disp   <= r_pend;
        r_pend_v <= 1'b0;
      end else if (load && !r_pend_v) begin
        r_pend   <= data_in;
        r_pend_v <= 1'b1;
      end
    end
  end

  assign ready      = ~r_pend_v;
  assign frame_done = w_frame_end;
  assign s_muxfue   = r_disp[r_idx];
  assign w_an_scan  = ~(N_DIG'(1) << r_idx);

`ifdef DISP_LZB_EN
  // w_nz_hi[i] is set when any digit from i up to the top is nonzero.
  logic [N_DIG-1:0] w_nz_hi;
  logic             w_acc;

  always_comb begin
    w_nz_hi = '0;
    w_acc   = 1'b0;
    for (int i = N_DIG - 1; i >= 0; i--) begin
      w_acc      = w_acc | (|r_disp[i]);
      w_nz_hi[i] = w_acc;
    end
  end

  assign an = ((r_idx != '0) && !w_nz_hi[r_idx]) ? '1 : w_an_scan;
`else
  assign an = w_an_scan;
`endif
endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux (N_DIG=4, REFRESH_DIV=4); expectations come from a cycle-count model.
module tb_display_scan_mux;
  localparam int N = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic        ready;
  logic [3:0]  s_muxfue;
  logic [3:0]  an;
  logic        frame_done;

  display_scan_mux #(.N_DIG(N), .REFRESH_DIV(D)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .ready(ready), .s_muxfue(s_muxfue), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [15:0] disp_m = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_an(input int c, input logic [15:0] v);
    int i;
    logic [3:0] a;
    i = (c / D) % N;
    a = ~(4'(1) << i);
`ifdef DISP_LZB_EN
    if (i > 0 && (v >> (4 * i)) == 16'h0) a = 4'hF;
`endif
    return a;
  endfunction

  task automatic scan_chk();
    int i;
    i = (cyc / D) % N;
    chk("an", 32'(an), 32'(exp_an(cyc, disp_m)));
    chk("s_muxfue", 32'(s_muxfue), 32'((disp_m >> (4 * i)) & 16'hF));
    chk("frame_done", 32'(frame_done), 32'((cyc % (N * D)) == N * D - 1));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // Reset state and two idle frames of zeros
    do_reset();
    disp_m = 16'h0;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_an", 32'(an), 32'hE);
    chk("rst_seg", 32'(s_muxfue), 32'h0);
    chk("rst_fdone", 32'(frame_done), 32'd0);
    repeat (32) begin scan_chk(); step(); end

    // Accepted load at cycle 2, ignored load at cycle 8, commit at frame end
    do_reset();
    disp_m = 16'h0;
    while (cyc < 2) begin scan_chk(); step(); end
    chk("ready_pre_load", 32'(ready), 32'd1);
    load = 1'b1; data_in = 16'hA3C5;
    scan_chk(); step();
    load = 1'b0;
    chk("ready_fall", 32'(ready), 32'd0);
    while (cyc < 16) begin
      if (cyc == 8) begin load = 1'b1; data_in = 16'h1111; end
      scan_chk();
      if (cyc == 15) chk("ready_before_commit", 32'(ready), 32'd0);
      step();
      load = 1'b0;
    end
    disp_m = 16'hA3C5;
    chk("ready_rise", 32'(ready), 32'd1);
    while (cyc < 31) begin scan_chk(); step(); end

    // Load landing exactly on a frame_end with empty buffer: committed one frame later
    chk("fe_ready", 32'(ready), 32'd1);
    load = 1'b1; data_in = 16'h0042;
    scan_chk(); step();
    load = 1'b0;
    chk("fe_ready_fall", 32'(ready), 32'd0);
    while (cyc < 48) begin scan_chk(); step(); end
    disp_m = 16'h0042;
    chk("fe_ready_rise", 32'(ready), 32'd1);
    while (cyc < 64) begin scan_chk(); step(); end

    // Reset mid-frame with a pending value: pending is discarded
    while (cyc < 69) begin scan_chk(); step(); end
    load = 1'b1; data_in = 16'h5555;
    scan_chk(); step();
    load = 1'b0;
    chk("pend_ready", 32'(ready), 32'd0);
    do_reset();
    disp_m = 16'h0;
    chk("mid_rst_an", 32'(an), 32'hE);
    chk("mid_rst_seg", 32'(s_muxfue), 32'h0);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    repeat (32) begin
      scan_chk();
      chk("no_pend_ready", 32'(ready), 32'd1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
